// File: rtl/food_manager.sv
// Food placement for the snake game: samples random grid cells until one is legal, then waits to be eaten.
// Optional FOOD_SCORE_EN builds the saturating 10-bit score counter; otherwise score is tied to 0.
module food_manager #(
  parameter int unsigned GRID      = 10,
  parameter int unsigned X_MAX     = 620,
  parameter int unsigned Y_MAX     = 460,
  parameter int unsigned INIT_X    = 320,
  parameter int unsigned INIT_Y    = 240,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       move_tick,
  input  logic [9:0] snakeX,
  input  logic [8:0] snakeY,
  input  logic [9:0] randomX,
  input  logic [8:0] randomY,
  output logic [9:0] foodX,
  output logic [8:0] foodY,
  output logic       food_valid,
  output logic       eaten,
  output logic [9:0] score
);

  localparam logic [9:0] GridX   = 10'(GRID);
  localparam logic [8:0] GridY   = 9'(GRID);
  localparam logic [9:0] XMax    = 10'(X_MAX);
  localparam logic [8:0] YMax    = 9'(Y_MAX);
  localparam logic [9:0] InitX   = 10'(INIT_X);
  localparam logic [8:0] InitY   = 9'(INIT_Y);
  localparam logic [9:0] AltX    = 10'(INIT_X + GRID);
  localparam logic [3:0] LastTry = 4'(MAX_TRIES - 1);

  typedef enum logic [0:0] {StSpawn, StActive} state_e;

  state_e     state_q, state_d;
  logic [9:0] food_x_q, food_x_d;
  logic [8:0] food_y_q, food_y_d;
  logic       valid_q, valid_d;
  logic       eaten_q, eaten_d;
  logic [3:0] try_q, try_d;

  logic x_ok, y_ok, on_head, rand_ok, head_on_init, hit;

  assign x_ok = (randomX >= GridX) && (randomX <= XMax) && ((randomX % GridX) == 10'd0);
  assign y_ok = (randomY >= GridY) && (randomY <= YMax) && ((randomY % GridY) == 9'd0);
  assign on_head      = (randomX == snakeX) && (randomY == snakeY);
  assign rand_ok      = x_ok && y_ok && !on_head;
  assign head_on_init = (snakeX == InitX) && (snakeY == InitY);
  // Collision is only evaluated on a move strobe while food is live.
  assign hit = (state_q == StActive) && move_tick && (snakeX == food_x_q) && (snakeY == food_y_q);

  always_comb begin
    state_d  = state_q;
    food_x_d = food_x_q;
    food_y_d = food_y_q;
    valid_d  = valid_q;
    eaten_d  = 1'b0;
    try_d    = try_q;
    unique case (state_q)
      StSpawn: begin
        if (rand_ok) begin
          food_x_d = randomX;
          food_y_d = randomY;
          valid_d  = 1'b1;
          try_d    = 4'd0;
          state_d  = StActive;
        end else if (try_q == LastTry) begin
          food_x_d = head_on_init ? AltX : InitX;
          food_y_d = InitY;
          valid_d  = 1'b1;
          try_d    = 4'd0;
          state_d  = StActive;
        end else begin
          try_d = try_q + 4'd1;
        end
      end
      StActive: begin
        if (hit) begin
          eaten_d = 1'b1;
          valid_d = 1'b0;
          try_d   = 4'd0;
          state_d = StSpawn;
        end
      end
      default: state_d = StSpawn;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= StSpawn;
      food_x_q <= InitX;
      food_y_q <= InitY;
      valid_q  <= 1'b0;
      eaten_q  <= 1'b0;
      try_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      food_x_q <= food_x_d;
      food_y_q <= food_y_d;
      valid_q  <= valid_d;
      eaten_q  <= eaten_d;
      try_q    <= try_d;
    end
  end

  assign foodX      = food_x_q;
  assign foodY      = food_y_q;
  assign food_valid = valid_q;
  assign eaten      = eaten_q;

`ifdef FOOD_SCORE_EN
  logic [9:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (hit && (score_q != 10'd1023)) score_d = score_q + 10'd1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) score_q <= 10'd0;
    else       score_q <= score_d;
  end

  assign score = score_q;
`else
  assign score = 10'd0;
`endif

endmodule

// File: tb/tb_food_manager.sv
// Directed self-checking bench for food_manager; score expectations follow FOOD_SCORE_EN.
module tb_food_manager;

  logic       clk = 1'b0;
  logic       reset;
  logic       move_tick;
  logic [9:0] snake_x;
  logic [8:0] snake_y;
  logic [9:0] rand_x;
  logic [8:0] rand_y;
  logic [9:0] food_x;
  logic [8:0] food_y;
  logic       food_valid;
  logic       eaten;
  logic [9:0] score;

  int n_pass  = 0;
  int n_total = 0;

  food_manager dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .move_tick (move_tick),
    .snakeX    (snake_x),
    .snakeY    (snake_y),
    .randomX   (rand_x),
    .randomY   (rand_y),
    .foodX     (food_x),
    .foodY     (food_y),
    .food_valid(food_valid),
    .eaten     (eaten),
    .score     (score)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [9:0] hx, input logic [8:0] hy,
                        input logic [9:0] rx, input logic [8:0] ry, input logic tick);
    snake_x   = hx;
    snake_y   = hy;
    rand_x    = rx;
    rand_y    = ry;
    move_tick = tick;
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    set_in(10'd0, 9'd0, 10'd100, 9'd50, 1'b0);
    hold_reset();
    n_total++;
    if (food_x !== 10'd320) $display("FAIL reset_food_x got %0d want 320", food_x);
    else n_pass++;
    n_total++;
    if (food_y !== 9'd240) $display("FAIL reset_food_y got %0d want 240", food_y);
    else n_pass++;
    n_total++;
    if (food_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", food_valid);
    else n_pass++;
    n_total++;
    if (eaten !== 1'b0) $display("FAIL reset_eaten got %b want 0", eaten);
    else n_pass++;
    n_total++;
    if (score !== 10'd0) $display("FAIL reset_score got %0d want 0", score);
    else n_pass++;
  endtask

  // Continues from test_reset: reset still asserted, random=(100,50), head=(0,0).
  task automatic test_spawn_accept();
    reset = 1'b0;
    step();
    n_total++;
    if (food_x !== 10'd100 || food_y !== 9'd50)
      $display("FAIL accept_pos got (%0d,%0d) want (100,50)", food_x, food_y);
    else n_pass++;
    n_total++;
    if (food_valid !== 1'b1) $display("FAIL accept_valid got %b want 1", food_valid);
    else n_pass++;
  endtask

  task automatic test_no_tick();
    set_in(10'd100, 9'd50, 10'd0, 9'd0, 1'b0);
    step();
    n_total++;
    if (eaten !== 1'b0 || food_valid !== 1'b1)
      $display("FAIL no_tick got eaten=%b valid=%b want 0/1", eaten, food_valid);
    else n_pass++;
  endtask

  task automatic test_eat();
    logic [9:0] exp_score;
`ifdef FOOD_SCORE_EN
    exp_score = 10'd1;
`else
    exp_score = 10'd0;
`endif
    set_in(10'd100, 9'd50, 10'd0, 9'd0, 1'b1);
    step();
    n_total++;
    if (eaten !== 1'b1) $display("FAIL eat_pulse got %b want 1", eaten);
    else n_pass++;
    n_total++;
    if (food_valid !== 1'b0) $display("FAIL eat_valid got %b want 0", food_valid);
    else n_pass++;
    n_total++;
    if (score !== exp_score) $display("FAIL eat_score got %0d want %0d", score, exp_score);
    else n_pass++;
    n_total++;
    if (food_x !== 10'd100 || food_y !== 9'd50)
      $display("FAIL eat_hold_pos got (%0d,%0d) want (100,50)", food_x, food_y);
    else n_pass++;
    // Still colliding with tick high, but now in SPAWN: no second pulse.
    step();
    n_total++;
    if (eaten !== 1'b0) $display("FAIL spawn_ignores_tick got eaten=%b want 0", eaten);
    else n_pass++;
    n_total++;
    if (score !== exp_score) $display("FAIL spawn_score_hold got %0d want %0d", score, exp_score);
    else n_pass++;
  endtask

  task automatic test_fallback();
    set_in(10'd0, 9'd0, 10'd0, 9'd0, 1'b0);
    hold_reset();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) step();
    n_total++;
    if (food_valid !== 1'b0) $display("FAIL fallback_early got valid=%b want 0", food_valid);
    else n_pass++;
    step();
    n_total++;
    if (food_valid !== 1'b1 || food_x !== 10'd320 || food_y !== 9'd240)
      $display("FAIL fallback_init got v=%b (%0d,%0d) want 1 (320,240)",
               food_valid, food_x, food_y);
    else n_pass++;
    // Head on INIT: alternate fallback cell.
    set_in(10'd320, 9'd240, 10'd0, 9'd0, 1'b0);
    hold_reset();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step();
    n_total++;
    if (food_valid !== 1'b1 || food_x !== 10'd330 || food_y !== 9'd240)
      $display("FAIL fallback_alt got v=%b (%0d,%0d) want 1 (330,240)",
               food_valid, food_x, food_y);
    else n_pass++;
  endtask

  task automatic test_head_reject();
    set_in(10'd200, 9'd100, 10'd200, 9'd100, 1'b0);
    hold_reset();
    reset = 1'b0;
    step();
    n_total++;
    if (food_valid !== 1'b0) $display("FAIL head_reject got valid=%b want 0", food_valid);
    else n_pass++;
    rand_x = 10'd210;
    step();
    n_total++;
    if (food_valid !== 1'b1 || food_x !== 10'd210 || food_y !== 9'd100)
      $display("FAIL head_next got v=%b (%0d,%0d) want 1 (210,100)", food_valid, food_x, food_y);
    else n_pass++;
  endtask

  task automatic test_bounds();
    set_in(10'd0, 9'd0, 10'd630, 9'd50, 1'b0);
    hold_reset();
    reset = 1'b0;
    step();
    n_total++;
    if (food_valid !== 1'b0) $display("FAIL bound_x_over got valid=%b want 0", food_valid);
    else n_pass++;
    rand_x = 10'd105;
    step();
    n_total++;
    if (food_valid !== 1'b0) $display("FAIL bound_not_grid got valid=%b want 0", food_valid);
    else n_pass++;
    rand_x = 10'd100;
    rand_y = 9'd470;
    step();
    n_total++;
    if (food_valid !== 1'b0) $display("FAIL bound_y_over got valid=%b want 0", food_valid);
    else n_pass++;
    rand_x = 10'd620;
    rand_y = 9'd460;
    step();
    n_total++;
    if (food_valid !== 1'b1 || food_x !== 10'd620 || food_y !== 9'd460)
      $display("FAIL bound_max got v=%b (%0d,%0d) want 1 (620,460)", food_valid, food_x, food_y);
    else n_pass++;
    set_in(10'd0, 9'd0, 10'd10, 9'd10, 1'b0);
    hold_reset();
    reset = 1'b0;
    step();
    n_total++;
    if (food_valid !== 1'b1 || food_x !== 10'd10 || food_y !== 9'd10)
      $display("FAIL bound_min got v=%b (%0d,%0d) want 1 (10,10)", food_valid, food_x, food_y);
    else n_pass++;
  endtask

  task automatic test_reset_priority();
    set_in(10'd0, 9'd0, 10'd100, 9'd50, 1'b0);
    hold_reset();
    reset = 1'b0;
    step();
    set_in(10'd100, 9'd50, 10'd0, 9'd0, 1'b1);
    reset = 1'b1;
    step();
    n_total++;
    if (eaten !== 1'b0) $display("FAIL rst_prio_eaten got %b want 0", eaten);
    else n_pass++;
    n_total++;
    if (food_valid !== 1'b0 || food_x !== 10'd320 || food_y !== 9'd240 || score !== 10'd0)
      $display("FAIL rst_prio_state got v=%b (%0d,%0d) score=%0d want 0 (320,240) 0",
               food_valid, food_x, food_y, score);
    else n_pass++;
    reset     = 1'b0;
    move_tick = 1'b0;
  endtask

  task automatic test_score_sat();
    int n_eaten = 0;
    logic [9:0] exp_score;
`ifdef FOOD_SCORE_EN
    exp_score = 10'd1023;
`else
    exp_score = 10'd0;
`endif
    set_in(10'd0, 9'd0, 10'd100, 9'd50, 1'b0);
    hold_reset();
    reset = 1'b0;
    for (int i = 0; i < 1030; i++) begin
      set_in(10'd0, 9'd0, 10'd100, 9'd50, 1'b0);
      step();
      set_in(10'd100, 9'd50, 10'd100, 9'd50, 1'b1);
      step();
      if (eaten === 1'b1) n_eaten++;
    end
    move_tick = 1'b0;
    n_total++;
    if (n_eaten != 1030) $display("FAIL sat_eat_count got %0d want 1030", n_eaten);
    else n_pass++;
    n_total++;
    if (score !== exp_score) $display("FAIL sat_score got %0d want %0d", score, exp_score);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    set_in(10'd0, 9'd0, 10'd0, 9'd0, 1'b0);
    test_reset();
    test_spawn_accept();
    test_no_tick();
    test_eat();
    test_fallback();
    test_head_reject();
    test_bounds();
    test_reset_priority();
    test_score_sat();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
